// File: rtl/ram_boot_loader_if.sv
// ram_boot_loader_if: byte-stream input and RAM firmware-download port of the boot loader
interface ram_boot_loader_if #(parameter int AWIDTH = 15);
  logic [7:0] in_data_i;
  logic in_valid_i;
  logic in_ready_o;
  logic [AWIDTH-1:0] ram_loader_adr_o;
  logic [31:0] ram_loader_dat_o;
  logic [3:0] ram_loader_sel_o;
  logic ram_loader_stb_o;
  logic ram_loader_we_o;
  logic ram_loader_done_o;
  modport master(
    input in_data_i, in_valid_i,
    output in_ready_o, ram_loader_adr_o, ram_loader_dat_o, ram_loader_sel_o,
    output ram_loader_stb_o, ram_loader_we_o, ram_loader_done_o
  );
  modport slave(
    output in_data_i, in_valid_i,
    input in_ready_o, ram_loader_adr_o, ram_loader_dat_o, ram_loader_sel_o,
    input ram_loader_stb_o, ram_loader_we_o, ram_loader_done_o
  );
endinterface

// File: rtl/ram_boot_loader.sv
// ram_boot_loader: parses a length-prefixed byte stream and writes it big-endian into boot RAM
module ram_boot_loader #(
  parameter int AWIDTH = 15,
  parameter int RAM_SIZE = 16384,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input logic wb_clk_i,
  input logic wb_rst_n_i,
  input logic start_i,
  output logic busy_o,
  output logic error_o,
  ram_boot_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;
  state_t state;
  logic [31:0] len, word, len_nxt, word_nxt, adr_nxt;
  logic [1:0] bcnt;
  logic [15:0] tcnt;
  logic [AWIDTH-1:0] waddr;
  logic xfer, timed_out, hdr_bad;
  assign xfer = bus.in_valid_i & bus.in_ready_o;
  assign len_nxt = {len[23:0], bus.in_data_i};
  assign word_nxt = {word[23:0], bus.in_data_i};
  assign adr_nxt = 32'(waddr) + 32'd4;
  assign hdr_bad = len_nxt == 32'd0 || len_nxt[1:0] != 2'd0 || len_nxt > 32'(RAM_SIZE);
  // a transfer on the final stalled cycle rescues the load
  assign timed_out = TIMEOUT != 16'd0 && !xfer && tcnt == TIMEOUT - 16'd1;
  assign bus.ram_loader_sel_o = 4'hF;
  assign bus.ram_loader_we_o = bus.ram_loader_stb_o;
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
      len <= '0;
      word <= '0;
      bcnt <= '0;
      tcnt <= '0;
      waddr <= '0;
      bus.in_ready_o <= 1'b0;
      bus.ram_loader_adr_o <= '0;
      bus.ram_loader_dat_o <= '0;
      bus.ram_loader_stb_o <= 1'b0;
      bus.ram_loader_done_o <= 1'b0;
      busy_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      case (state)
        IDLE, ERR: if (start_i) begin
          state <= HDR;
          len <= '0;
          bcnt <= '0;
          tcnt <= '0;
          waddr <= '0;
          bus.in_ready_o <= 1'b1;
          busy_o <= 1'b1;
          error_o <= 1'b0;
        end
        HDR, DATA: if (timed_out) begin
          state <= ERR;
          bus.in_ready_o <= 1'b0;
          busy_o <= 1'b0;
          error_o <= 1'b1;
        end else if (xfer) begin
          tcnt <= '0;
          bcnt <= bcnt + 2'd1;
          if (state == HDR) len <= len_nxt;
          else word <= word_nxt;
          if (bcnt == 2'd3 && state == HDR && hdr_bad) begin
            state <= ERR;
            bus.in_ready_o <= 1'b0;
            busy_o <= 1'b0;
            error_o <= 1'b1;
          end else if (bcnt == 2'd3 && state == HDR) begin
            state <= DATA;
          end else if (bcnt == 2'd3) begin
            state <= WRITE;
            bus.in_ready_o <= 1'b0;
            bus.ram_loader_stb_o <= 1'b1;
            bus.ram_loader_adr_o <= waddr;
            bus.ram_loader_dat_o <= word_nxt;
          end
        end else begin
          tcnt <= tcnt + 16'd1;
        end
        WRITE: begin
          bus.ram_loader_stb_o <= 1'b0;
          waddr <= waddr + AWIDTH'(4);
          if (adr_nxt == len) begin
            state <= DONE;
            bus.ram_loader_done_o <= 1'b1;
            busy_o <= 1'b0;
          end else begin
            state <= DATA;
            bus.in_ready_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_boot_loader.sv
// tb_ram_boot_loader: randomized image loads checked against a queue-based model of the boot image
module tb_ram_boot_loader;
  localparam int RAM_SIZE = 16384;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, error;
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, first_stb = 0, last_stb = 0, done_at = 0;
  logic done_q = 1'b0;
  logic [14:0] got_adr[$];
  logic [31:0] got_dat[$];
  ram_boot_loader_if #(.AWIDTH(15)) bus();
  ram_boot_loader #(.AWIDTH(15), .RAM_SIZE(RAM_SIZE), .TIMEOUT(16'd16)) dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .start_i(start),
    .busy_o(busy),
    .error_o(error),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.ram_loader_stb_o === 1'b1) begin
      if (got_adr.size() == 0) first_stb = cyc;
      last_stb = cyc;
      got_adr.push_back(bus.ram_loader_adr_o);
      got_dat.push_back(bus.ram_loader_dat_o);
      check("we", bus.ram_loader_we_o, 1);
      check("sel", bus.ram_loader_sel_o, 4'hF);
    end
    if (bus.ram_loader_done_o === 1'b1 && done_q !== 1'b1) done_at = cyc;
    done_q = bus.ram_loader_done_o;
  end
  task automatic rst_dut();
    rst_n = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    check("rst_out", {bus.in_ready_o, bus.ram_loader_stb_o, bus.ram_loader_we_o, bus.ram_loader_done_o,
      busy, error, bus.ram_loader_sel_o, bus.ram_loader_adr_o, bus.ram_loader_dat_o}, {6'b0, 4'hF, 15'b0, 32'b0});
    rst_n = 1'b1;
    got_adr.delete();
    got_dat.delete();
  endtask
  task automatic start_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rdy_rise", bus.in_ready_o, 1);
    check("err_clr", error, 0);
    check("busy", busy, 1);
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    bus.in_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.in_data_i = b;
    for (int t = 0; t < 100 && bus.in_ready_o !== 1'b1; t++) @(negedge clk);
    if (bus.in_ready_o !== 1'b1) check("rdy_wait", bus.in_ready_o, 1);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask
  task automatic wait_done();
    for (int t = 0; t < 20 && bus.ram_loader_done_o !== 1'b1; t++) @(negedge clk);
    check("done", bus.ram_loader_done_o, 1);
  endtask
  task automatic run_image(input logic [31:0] len, input int maxgap, input bit poke);
    logic [31:0] exp_dat[$];
    logic [31:0] w;
    logic [7:0] b;
    int n0;
    bit bad;
    w = '0;
    got_adr.delete();
    got_dat.delete();
    bad = len == 0 || len % 4 != 0 || len > RAM_SIZE;
    start_load();
    for (int i = 3; i >= 0; i--) send(len[8*i +: 8], $urandom_range(0, maxgap));
    if (bad) begin
      check("hdr_err", error, 1);
      check("hdr_rdy", bus.in_ready_o, 0);
      check("hdr_done", bus.ram_loader_done_o, 0);
      repeat (3) @(negedge clk);
      check("hdr_nowr", got_adr.size(), 0);
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      if (poke) start = (i == 5);
      send(b, $urandom_range(0, maxgap));
      w = w * 256 + 32'(b);
      if (i % 4 == 3) exp_dat.push_back(w);
    end
    start = 1'b0;
    wait_done();
    check("err_low", error, 0);
    check("rdy_low", bus.in_ready_o, 0);
    check("busy_low", busy, 0);
    check("done_lat", done_at, last_stb + 1);
    check("n_wr", got_adr.size(), len / 4);
    for (int i = 0; i < got_adr.size() && i < exp_dat.size(); i++) begin
      check("adr", got_adr[i], 4 * i);
      check("dat", got_dat[i], exp_dat[i]);
    end
    if (maxgap == 0) check("rate", last_stb - first_stb, 5 * (len / 4 - 1));
    if (poke) begin
      n0 = got_adr.size();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("ign_done", bus.ram_loader_done_o, 1);
      check("ign_rdy", bus.in_ready_o, 0);
      check("ign_wr", got_adr.size(), n0);
    end
    rst_dut();
  endtask
  initial begin
    logic [7:0] basic[12];
    logic [31:0] bad_len;
    basic = '{8'h00, 8'h00, 8'h00, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    bus.in_valid_i = 1'b0;
    bus.in_data_i = 8'h00;
    repeat (2) @(negedge clk);
    rst_dut();
    start_load();
    foreach (basic[i]) send(basic[i], 0);
    wait_done();
    check("b_n", got_adr.size(), 2);
    if (got_adr.size() >= 2) begin
      check("b_a0", got_adr[0], 15'h0000);
      check("b_d0", got_dat[0], 32'hDEADBEEF);
      check("b_a1", got_adr[1], 15'h0004);
      check("b_d1", got_dat[1], 32'h01020304);
    end
    check("b_lat", done_at, last_stb + 1);
    check("b_err", error, 0);
    check("b_rdy", bus.in_ready_o, 0);
    rst_dut();
    run_image(32'd6, 0, 1'b0);
    run_image(32'd4, 0, 1'b0);
    run_image(32'h4004, 2, 1'b0);
    run_image(32'd0, 2, 1'b0);
    run_image(32'h4000, 0, 1'b0);
    start_load();
    repeat (15) @(negedge clk);
    check("to_hdr_15", error, 0);
    @(negedge clk);
    check("to_hdr_16", error, 1);
    rst_dut();
    start_load();
    foreach (basic[i]) if (i < 4) send(basic[i], 0);
    send(8'h11, 0);
    send(8'h12, 0);
    send(8'h13, 15);
    for (int i = 4; i < 9; i++) send(8'h10 + 8'(i), 0);
    wait_done();
    check("to15_n", got_adr.size(), 2);
    if (got_adr.size() >= 2) begin
      check("to15_d0", got_dat[0], 32'h11121314);
      check("to15_d1", got_dat[1], 32'h15161718);
    end
    rst_dut();
    start_load();
    foreach (basic[i]) if (i < 4) send(basic[i], 0);
    send(8'h11, 0);
    send(8'h12, 0);
    repeat (15) @(negedge clk);
    check("to16_early", error, 0);
    @(negedge clk);
    check("to16_err", error, 1);
    check("to16_rdy", bus.in_ready_o, 0);
    check("to16_nowr", got_adr.size(), 0);
    rst_dut();
    start_load();
    for (int i = 3; i >= 0; i--) send(8'(32'd32 >> (8 * i)), 0);
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 0);
    check("mid_stb", bus.ram_loader_stb_o, 1);
    check("mid_wr", got_adr.size(), 1);
    rst_dut();
    run_image(32'd32, 1, 1'b0);
    run_image(32'd32, 2, 1'b1);
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        bad_len = $urandom_range(0, 1) ? 32'(RAM_SIZE) + 32'd4 * $urandom_range(1, 1000)
                                       : 32'd4 * $urandom_range(0, 40) + 32'($urandom_range(1, 3));
        run_image(bad_len, $urandom_range(0, 4), 1'b0);
      end else begin
        run_image(32'd4 * $urandom_range(1, 16), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_boot_loader.md
# ram_boot_loader

Sequencer that brings up the Harvard boot RAM from a byte stream, such as an SPI boot-flash reader or a host download path. It parses a 4-byte length header, then packs payload bytes big-endian into 32-bit words. Each word is written through the RAM's firmware-download port at consecutive word-aligned byte addresses. When the image is complete it asserts `done_o`, which hands RAM port 1 over to instruction fetch; it reports malformed or stalled images on `error_o`.

## Interface
Parameters:
- `AWIDTH`, 15: RAM byte-address width.
- `RAM_SIZE`, 16384: RAM capacity in bytes; maximum legal image length.
- `TIMEOUT`, 65535: idle cycles allowed between accepted bytes before error; 0 disables the timeout (16-bit value).

Ports:
- `wb_clk_i`  in  1  clock; everything is on the rising edge.
- `wb_rst_n_i`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  begin a load; sampled only in IDLE or ERR.
- `in_data_i`  in  8  stream byte.
- `in_valid_i`  in  1  `in_data_i` is valid.
- `in_ready_o`  out  1  loader can accept a byte; a transfer happens when `in_valid_i & in_ready_o`.
- `ram_loader_adr_o`  out  AWIDTH  write byte address, word-aligned.
- `ram_loader_dat_o`  out  32  write word.
- `ram_loader_sel_o`  out  4  byte enables; constant 4'hF.
- `ram_loader_stb_o`  out  1  write strobe.
- `ram_loader_we_o`  out  1  write enable; identical to `stb_o`.
- `ram_loader_done_o`  out  1  image loaded; sticky until reset.
- `busy_o`  out  1  state is HDR, DATA or WRITE.
- `error_o`  out  1  load failed; sticky until the next `start_i` or reset.

## Operation
States are IDLE, HDR, DATA, WRITE, DONE and ERR.
- IDLE: `in_ready_o`=0. `start_i`=1 → HDR. Entering HDR clears the header byte count, the length register, the address and the timeout counter.
- HDR: `in_ready_o`=1. Accept 4 bytes MSB-first into the 32-bit `len`. After the 4th byte:
  - `len`==0, `len[1:0]`!=0, or `len`>`RAM_SIZE` → ERR.
  - Otherwise → DATA.
- DATA: `in_ready_o`=1. Bytes shift into the word register, first byte in [31:24], 4th byte in [7:0]. After the 4th byte → WRITE.
- WRITE: `in_ready_o`=0. `stb_o`=`we_o`=1 for exactly one cycle, with `adr_o`=current address and `dat_o`=the assembled word. Then the address advances by 4.
  - Bytes written (address+4) == `len` → DONE.
  - Otherwise → DATA.
- DONE: `ram_loader_done_o`=1, `in_ready_o`=0. `start_i` is ignored; only reset leaves DONE.
- ERR: `error_o`=1, `in_ready_o`=0, `ram_loader_done_o`=0. `start_i` → HDR and clears `error_o` on the same edge.
- Timeout: the counter increments on every cycle in HDR/DATA without a transfer and clears on each transfer. When it reaches `TIMEOUT` (nonzero) → ERR. Bytes already written stay in RAM.
- `start_i` in HDR, DATA, WRITE or DONE has no effect.
- `adr_o` and `dat_o` hold their last value outside WRITE; `stb_o`/`we_o` are the only qualifiers.

## Timing
- Reset values:
  - All outputs are 0 (`sel_o` = 4'hF); state is IDLE.
  - Counters, `len` and the word register are cleared.
- Reset during a load:
  - Next cycle is IDLE with `done_o` low, so instruction fetch stays locked out.
  - Partial RAM contents are not erased.
- `in_ready_o` rises the cycle after `start_i` is sampled.
- `stb_o` asserts the cycle after the 4th byte of a word is accepted; sustained throughput is 5 cycles per word.
- The write is fire-and-forget: the download port needs no acknowledge.
- `done_o` rises the cycle after the final `stb_o` pulse. Header error → `error_o` rises the cycle after the 4th header byte.
- The timeout fires exactly `TIMEOUT` stalled cycles after the last transfer (or after HDR entry); `error_o` is high on the following cycle.
- Maximum image: `len`=`RAM_SIZE`; the last address is `RAM_SIZE`-4, and the address never wraps.

## Test plan
- **Basic load.** Reset, then `start_i`, then stream 00 00 00 08 DE AD BE EF 01 02 03 04 with `in_valid_i` held high.
  - Two `stb_o` pulses: (adr 0x0000, 0xDEADBEEF) and (adr 0x0004, 0x01020304), `sel_o`=F.
  - `done_o`=1 the cycle after the second pulse; `in_ready_o`=0 after that; `error_o`=0 throughout.
- **Misaligned length.** Header 00 00 00 06 → `error_o`=1, no `stb_o`, `in_ready_o`=0. A following `start_i` with a valid 4-byte image completes.
- **Length bounds** (`RAM_SIZE`=16384).
  - Header 0x00004004 → error.
  - Header 0x00004000 → 4096 writes, last adr 0x3FFC, then done.
  - Header 0 → error.
- **Timeout** (`TIMEOUT`=16). Drop `in_valid_i` after the 2nd payload byte.
  - A 15-cycle gap still completes.
  - A 16-cycle gap → `error_o`, with no write for the partial word.
- **Reset mid-load.** Assert `wb_rst_n_i`=0 for one cycle after the first `stb_o` of an 8-word image.
  - Next cycle: all outputs are at reset values.
  - A restart rewrites from adr 0 and finishes with `done_o`.
- **Ignored start.** Pulse `start_i` during DATA and again in DONE → no state change, the address sequence is unaffected, and `done_o` stays 1.
